// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: sole master of the pipelined main memory; arbitrates D-cache stores and I/D miss fills.
// Optional build macro CRITICAL_WORD_FIRST_EN streams the missed word first and wraps through the block.
module cache_fill_arbiter #(
  parameter  int ADDR_W        = 16,
  parameter  int DATA_W        = 16,
  parameter  int WORDS_PER_BLK = 8,
  parameter  int MEM_LAT       = 4,
  localparam int IDX_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss_req,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  input  logic              dc_miss_req,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic              ic_fill_we,
  output logic              dc_fill_we,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              ic_fill_done,
  output logic              dc_fill_done,
  output logic              dc_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic              busy
);

  localparam int OFF_W  = IDX_W + 1;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam int DCNT_W = $clog2(MEM_LAT + 1);

  localparam logic [2:0] S_DRAIN  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_FILL_I = 3'd3;
  localparam logic [2:0] S_FILL_D = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  crit_q, crit_d;
  logic [IDX_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic              issue_done_q, issue_done_d;
  logic              last_d_side_q, last_d_side_d;

  logic              pick_w, pick_d, pick_i;
  logic [ADDR_W-1:0] grant_addr;
  logic [IDX_W-1:0]  issue_idx, recv_idx;
  logic              unused_low_bits;

  // One-shot fairness: a waiting I-miss beats everything right after any D-side transaction.
  always_comb begin
    pick_w = 1'b0;
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (last_d_side_q && ic_miss_req) pick_i = 1'b1;
    else if (dc_wr_req)               pick_w = 1'b1;
    else if (dc_miss_req)             pick_d = 1'b1;
    else if (ic_miss_req)             pick_i = 1'b1;
  end

  assign grant_addr      = pick_d ? dc_miss_addr : ic_miss_addr;
  assign unused_low_bits = ^grant_addr[OFF_W-1:0];
  assign issue_idx       = crit_q + issue_cnt_q;
  assign recv_idx        = crit_q + recv_cnt_q;
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    base_d        = base_q;
    crit_d        = crit_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    issue_done_d  = issue_done_q;
    last_d_side_d = last_d_side_q;
    ic_fill_we    = 1'b0;
    dc_fill_we    = 1'b0;
    fill_word_idx = '0;
    fill_data     = '0;
    ic_fill_done  = 1'b0;
    dc_fill_done  = 1'b0;
    dc_wr_ack     = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    case (state_q)
      // Holds MEM_LAT full cycles after reset release so stale read returns land here and are dropped.
      S_DRAIN: begin
        if (drain_cnt_q == DCNT_W'(MEM_LAT)) state_d = S_IDLE;
        else drain_cnt_d = drain_cnt_q + DCNT_W'(1);
      end
      S_IDLE: begin
        issue_cnt_d  = '0;
        recv_cnt_d   = '0;
        issue_done_d = 1'b0;
        base_d       = grant_addr[ADDR_W-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
        crit_d       = grant_addr[OFF_W-1:1];
`else
        crit_d       = '0;
`endif
        if (pick_w) begin
          state_d       = S_WRITE;
          last_d_side_d = 1'b1;
        end else if (pick_d) begin
          state_d       = S_FILL_D;
          last_d_side_d = 1'b1;
        end else if (pick_i) begin
          state_d       = S_FILL_I;
          last_d_side_d = 1'b0;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dc_wr_addr;
        mem_wdata = dc_wr_data;
        dc_wr_ack = 1'b1;
        state_d   = S_IDLE;
      end
      S_FILL_I, S_FILL_D: begin
        if (!issue_done_q) begin
          mem_en       = 1'b1;
          mem_addr     = {base_q, issue_idx, 1'b0};
          issue_cnt_d  = issue_cnt_q + IDX_W'(1);
          issue_done_d = (issue_cnt_q == {IDX_W{1'b1}});
        end
        if (mem_data_valid) begin
          ic_fill_we    = (state_q == S_FILL_I);
          dc_fill_we    = (state_q == S_FILL_D);
          fill_word_idx = recv_idx;
          fill_data     = mem_rdata;
          recv_cnt_d    = recv_cnt_q + IDX_W'(1);
          if (recv_cnt_q == {IDX_W{1'b1}}) begin
            ic_fill_done = (state_q == S_FILL_I);
            dc_fill_done = (state_q == S_FILL_D);
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_DRAIN;
      drain_cnt_q   <= '0;
      base_q        <= '0;
      crit_q        <= '0;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      issue_done_q  <= 1'b0;
      last_d_side_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      base_q        <= base_d;
      crit_q        <= crit_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      issue_done_q  <= issue_done_d;
      last_d_side_q <= last_d_side_d;
    end
  end

endmodule
